// File: rtl/ls_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDrain,
    StResp
  } ls_state_e;

  // Number of byte accesses for a size code; 0 for the reserved code.
  function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ls_extend.sv
// Sign/zero extension of the assembled load bytes to 32 bits.
module ls_extend
  import ls_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Extend from bit 7 or bit 15; word passes through unchanged.
  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & acc_i[7]}}, acc_i[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & acc_i[15]}}, acc_i[15:0]};
      SZ_WORD: data_o = acc_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Splits one load/store request into 1, 2 or 4 big-endian byte accesses on a
// byte-wide memory port and returns extended load data or an alignment error.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  ls_state_e         state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_q, last_d;
  logic              err_q, err_d;
  logic              rd_pend_q, rd_pend_d;
  logic [31:0]       acc_q, acc_d;

  logic              req_bad;
  logic [2:0]        n_req;
  logic [2:0]        last_req;
  logic [1:0]        byte_sel;
  logic [31:0]       ext_data;

  // Misaligned half/word or reserved size is rejected without touching memory.
  always_comb begin
    req_bad = (req_size == SZ_RSVD) ||
              ((req_size == SZ_HALF) && req_addr[0]) ||
              ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    n_req    = bytes_for_size(req_size);
    last_req = n_req - 3'd1;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      k_q       <= '0;
      last_q    <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      k_q       <= k_d;
      last_q    <= last_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      acc_q     <= acc_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) state_d = req_bad ? StResp : StAccess;
      end
      StAccess: begin
        if (k_q == last_q) state_d = write_q ? StResp : StDrain;
      end
      StDrain: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request latch, byte counter and load shift register.
  always_comb begin
    write_d   = write_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    k_d       = k_q;
    last_d    = last_q;
    err_d     = err_q;
    acc_d     = acc_q;
    rd_pend_d = mem_re;

    if (state_q == StIdle && req_valid) begin
      write_d = req_write;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      k_d     = '0;
      // n-1 fits in two bits for every legal size (0, 1, 3).
      last_d  = last_req[1:0];
      err_d   = req_bad;
      acc_d   = '0;
    end else if (state_q == StAccess) begin
      k_d = k_q + 2'd1;
    end

    // Read data arrives the cycle after each strobe, so capture lags by one.
    if (rd_pend_q) acc_d = {acc_q[23:0], mem_rdata};
  end

  // Big-endian: byte k of an n-byte field is field byte (n-1-k) from the LSB.
  always_comb byte_sel = last_q - k_q;

  ls_extend u_extend (
    .acc_i      (acc_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  // FSM outputs: handshakes and memory strobes decoded from the current state.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err_q;
    resp_data  = ((state_q == StResp) && !err_q && !write_q) ? ext_data : '0;
    mem_re     = (state_q == StAccess) && !write_q;
    mem_we     = (state_q == StAccess) && write_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == StAccess) begin
      mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
      if (write_q) begin
        unique case (byte_sel)
          2'd0: mem_wdata = wdata_q[7:0];
          2'd1: mem_wdata = wdata_q[15:8];
          2'd2: mem_wdata = wdata_q[23:16];
          2'd3: mem_wdata = wdata_q[31:24];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-wide memory model.
module tb_load_store_unit;
  import ls_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic [31:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Byte memory: write on the strobe edge, read data valid the next cycle.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          st_cyc[$];
  logic        st_we[$];
  logic [31:0] st_addr[$];
  logic [7:0]  st_data[$];

  int errors = 0;
  int checks = 0;

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int ec,
                       output logic rdy);
    exp_t e;
    @(negedge clk);
    rdy          = req_ready;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    e.data = ed;
    e.err  = ee;
    e.cyc  = ec;
    sb.push_back(e);
    st_cyc.delete();
    st_we.delete();
    st_addr.delete();
    st_data.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid, logging strobes; optionally complete the handshake.
  task automatic collect(input logic ack, output logic [31:0] d, output logic e,
                         output int c, output logic to);
    c  = 0;
    d  = '0;
    e  = 1'b0;
    to = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        st_cyc.push_back(i);
        st_we.push_back(mem_we);
        st_addr.push_back(mem_addr);
        st_data.push_back(mem_wdata);
      end
      if (resp_valid) begin
        c  = i;
        d  = resp_data;
        e  = resp_err;
        to = 1'b0;
        break;
      end
    end
    if (!to && ack) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_re, mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 10000",
               {req_ready, resp_valid, resp_err, mem_re, mem_we});
    end
    checks++;
    if (resp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp_data: got %h, expected 0", resp_data);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h, expected 0/0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stores();
    logic [1:0]  sz[4] = '{SZ_WORD, SZ_HALF, SZ_BYTE, SZ_WORD};
    logic [31:0] ad[4] = '{32'h8, 32'h40, 32'h30, 32'h20};
    logic [31:0] wd[4] = '{32'hDEADBEEF, 32'h1234ABCD, 32'hFFFFFF01, 32'hAAAAAAAA};
    int          nb[4] = '{4, 2, 1, 4};
    logic [7:0]  eb[4][4] = '{'{8'hDE, 8'hAD, 8'hBE, 8'hEF}, '{8'hAB, 8'hCD, 8'h00, 8'h00},
                              '{8'h01, 8'h00, 8'h00, 8'h00}, '{8'hAA, 8'hAA, 8'hAA, 8'hAA}};
    logic [31:0] d;
    logic        e, to, rdy;
    int          c;
    exp_t        x;
    for (int t = 0; t < 4; t++) begin
      issue(1'b1, sz[t], 1'b0, ad[t], wd[t], 32'h0, 1'b0, nb[t] + 1, rdy);
      collect(1'b1, d, e, c, to);
      x = sb.pop_front();
      checks++;
      if (to || d !== x.data || e !== x.err || c != x.cyc) begin
        errors++;
        $display("FAIL store%0d_resp: got to=%b data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                 t, to, d, e, c, x.data, x.err, x.cyc);
      end
      checks++;
      if (st_cyc.size() != nb[t]) begin
        errors++;
        $display("FAIL store%0d_nstrobes: got %0d, expected %0d", t, st_cyc.size(), nb[t]);
      end
      for (int i = 0; i < st_cyc.size() && i < nb[t]; i++) begin
        checks++;
        if (st_cyc[i] != i + 1 || st_we[i] !== 1'b1 || st_addr[i] !== ad[t] + i ||
            st_data[i] !== eb[t][i]) begin
          errors++;
          $display("FAIL store%0d_byte%0d: got cyc=%0d we=%b addr=%h data=%h, expected cyc=%0d we=1 addr=%h data=%h",
                   t, i, st_cyc[i], st_we[i], st_addr[i], st_data[i], i + 1, ad[t] + i, eb[t][i]);
        end
      end
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz[7] = '{SZ_WORD, SZ_HALF, SZ_HALF, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_BYTE};
    logic        us[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad[7] = '{32'h8, 32'h8, 32'h8, 32'hA, 32'hB, 32'hB, 32'h30};
    logic [31:0] ex[7] = '{32'hDEADBEEF, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFBEEF,
                           32'hFFFFFFEF, 32'h000000EF, 32'h00000001};
    int          nb[7] = '{4, 2, 2, 2, 1, 1, 1};
    logic [31:0] d;
    logic        e, to, rdy;
    int          c;
    exp_t        x;
    for (int t = 0; t < 7; t++) begin
      issue(1'b0, sz[t], us[t], ad[t], 32'h0, ex[t], 1'b0, nb[t] + 2, rdy);
      collect(1'b1, d, e, c, to);
      x = sb.pop_front();
      checks++;
      if (to || d !== x.data || e !== x.err || c != x.cyc) begin
        errors++;
        $display("FAIL load%0d_resp: got to=%b data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                 t, to, d, e, c, x.data, x.err, x.cyc);
      end
      checks++;
      if (st_cyc.size() != nb[t]) begin
        errors++;
        $display("FAIL load%0d_nstrobes: got %0d, expected %0d", t, st_cyc.size(), nb[t]);
      end
      for (int i = 0; i < st_cyc.size() && i < nb[t]; i++) begin
        checks++;
        if (st_cyc[i] != i + 1 || st_we[i] !== 1'b0 || st_addr[i] !== ad[t] + i) begin
          errors++;
          $display("FAIL load%0d_byte%0d: got cyc=%0d we=%b addr=%h, expected cyc=%0d we=0 addr=%h",
                   t, i, st_cyc[i], st_we[i], st_addr[i], i + 1, ad[t] + i);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic        wr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz[5] = '{SZ_WORD, SZ_HALF, SZ_RSVD, SZ_WORD, SZ_HALF};
    logic [31:0] ad[5] = '{32'h6, 32'h5, 32'h8, 32'h6, 32'h5};
    logic [31:0] d;
    logic        e, to, rdy;
    int          c;
    exp_t        x;
    for (int t = 0; t < 5; t++) begin
      issue(wr[t], sz[t], 1'b0, ad[t], 32'h12345678, 32'h0, 1'b1, 1, rdy);
      collect(1'b1, d, e, c, to);
      x = sb.pop_front();
      checks++;
      if (to || d !== x.data || e !== x.err || c != x.cyc) begin
        errors++;
        $display("FAIL err%0d_resp: got to=%b data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                 t, to, d, e, c, x.data, x.err, x.cyc);
      end
      checks++;
      if (st_cyc.size() != 0) begin
        errors++;
        $display("FAIL err%0d_strobes: got %0d strobes, expected 0", t, st_cyc.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e, to, rdy;
    int          c;
    exp_t        x;
    issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 6, rdy);
    collect(1'b0, d, e, c, to);
    x = sb.pop_front();
    checks++;
    if (to || d !== x.data || e !== x.err || c != x.cyc) begin
      errors++;
      $display("FAIL bp_resp: got to=%b data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
               to, d, e, c, x.data, x.err, x.cyc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h err=%b ready=%b, expected 1/deadbeef/0/0",
                 i, resp_valid, resp_data, resp_err, req_ready);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    issue(1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, 32'h0000BEEF, 1'b0, 4, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_ready: got %b, expected 1", rdy);
    end
    collect(1'b1, d, e, c, to);
    x = sb.pop_front();
    checks++;
    if (to || d !== x.data || e !== x.err || c != x.cyc) begin
      errors++;
      $display("FAIL bp_next_resp: got to=%b data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
               to, d, e, c, x.data, x.err, x.cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        e, to, rdy;
    int          c;
    exp_t        x;
    issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 5, rdy);
    void'(sb.pop_back());  // abandoned: no response expected
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 8'h11) begin
      errors++;
      $display("FAIL rst_byte0: got we=%b addr=%h data=%h, expected 1/20/11",
               mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_strobes: got we=%b re=%b resp_valid=%b, expected 0/0/0",
               mem_we, mem_re, resp_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rst_after%0d: got resp_valid=%b req_ready=%b we=%b, expected 0/1/0",
                 i, resp_valid, req_ready, mem_we);
      end
    end
    // Bytes 0-1 of the store landed; 2-3 keep the earlier 0xAA fill.
    issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1122AAAA, 1'b0, 6, rdy);
    collect(1'b1, d, e, c, to);
    x = sb.pop_front();
    checks++;
    if (to || d !== x.data || e !== x.err || c != x.cyc) begin
      errors++;
      $display("FAIL rst_readback: got to=%b data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
               to, d, e, c, x.data, x.err, x.cyc);
    end
  endtask

  initial begin
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = SZ_BYTE;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences byte-serial accesses to the byte-wide data memory on behalf of the MEM stage. Sits between the pipeline's address/store-data producer and the data memory. Accepts one load/store request at a time and splits it into 1, 2 or 4 big-endian byte accesses. Returns sign- or zero-extended load data, or an alignment error, through a valid/ready response.

## Interface
- ADDR_W, 32, byte-address width of request and memory port
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset; one clock, sampled on rising edge of clk
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: zero-extend (lbu/lhu), else sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or reserved size
- mem_addr  out  ADDR_W  byte address
- mem_re  out  1  byte read strobe
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  read byte, valid the cycle after mem_re

## Operation
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields.
  - Set n = 1/2/4 bytes.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size 11 → RESP with resp_err=1, no memory strobes.
  - Otherwise → ACCESS with byte index k=0.
- ACCESS:
  - Each cycle drive mem_addr = base + k.
  - Assert mem_re or mem_we, then k++.
  - After byte n-1: loads → DRAIN, stores → RESP.
- Store byte order is big-endian; address base+0 gets the MSB of the sized field:
  - Word: [31:24],[23:16],[15:8],[7:0].
  - Half: [15:8],[7:0].
  - Byte: [7:0].
- Load capture:
  - Shift register acc = {acc[23:0], mem_rdata}, captured the cycle after each mem_re.
  - The last byte is captured in DRAIN.
- Extension to 32 bits from bit 7 (byte) or bit 15 (half), unless req_unsigned. Word is unchanged.
- RESP:
  - resp_valid=1.
  - resp_data and resp_err are held stable until resp_ready.
  - Then → IDLE.
- req_ready=0 in every state except IDLE. There is no request overlap.
- mem_re, mem_we and mem_addr are 0 outside ACCESS.

## Timing
- Accept handshake completes at edge E0. Cycle c means the cycle following E0+c-1.
- Load of n bytes:
  - Strobes in cycles 1..n.
  - DRAIN in cycle n+1.
  - resp_valid from cycle n+2 (word load: cycle 6).
- Store of n bytes:
  - Strobes in cycles 1..n.
  - resp_valid from cycle n+1.
- Error: resp_valid in cycle 1. No strobes.
- The RESP→IDLE handshake edge makes req_ready=1 in the next cycle. Minimum one idle cycle between requests.
- Address arithmetic base+k wraps modulo 2^ADDR_W. The alignment rule prevents wrap for half and word accesses.
- Reset values:
  - State IDLE, req_ready=1.
  - resp_valid=0, resp_data=0, resp_err=0.
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - acc=0.
- Reset mid-operation:
  - Abandon the access immediately. Strobes are low in the next cycle.
  - No response is produced. Bytes already written remain.
- req_valid while busy is ignored; no latching.

## Structure
- Package ls_pkg:
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - State enum.
  - Function bytes_for_size.
- Sub-module ls_extend (combinational): acc + size + unsigned → resp_data.
- Everything else, including FSM, counter, shift register and alignment check, is in load_store_unit.

## Test plan
- Word store then word load:
  - Store 0xDEADBEEF at 8: mem_we cycles 1–4 with addr 8..11 and data DE,AD,BE,EF. resp_valid in cycle 5, err=0.
  - Load word at 8 → resp_data=0xDEADBEEF at cycle 6.
- Half loads, with memory at 8..11 holding DE AD BE EF:
  - lh at 8 → 0xFFFFDEAD.
  - lhu at 8 → 0x0000DEAD.
  - lh at 10 → 0xFFFFBEEF.
  - Each responds in cycle 4.
- Byte loads on the same memory:
  - lb at 11 → 0xFFFFFFEF.
  - lbu at 11 → 0x000000EF.
  - lb of byte 0x01 → 0x00000001.
- Misaligned and reserved requests:
  - Word at 6, half at 5, and size 11 each give resp_err=1 and resp_data=0 in cycle 1.
  - mem_re and mem_we are never asserted.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after resp_valid.
  - Response stays stable and req_ready stays 0.
  - Next request is accepted the cycle after the handshake.
- Reset in ACCESS:
  - Drop rst_n during byte 2 of a word store.
  - Strobes are 0 in the next cycle and no response appears.
  - Bytes 0–1 are written and bytes 2–3 are untouched.
  - After release, req_ready=1.
